// File: rtl/rsfq_pkg.sv
// rsfq_pkg
//   Shared types and constants for the RSFQ pulse decoder.
//   - state_e      : decoder FSM states (IDLE, OPEN)
//   - err_code_e   : bit positions of the per-cycle error event vector
//   - SYNC_MIN     : smallest usable synchroniser depth
//   - err_weight() : number of error events raised in one cycle
package rsfq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ERR_DOUBLE = 2'd0,
    ERR_ORPHAN = 2'd1,
    ERR_RATE   = 2'd2
  } err_code_e;

  localparam int ERR_N    = 3;
  localparam int SYNC_MIN = 2;

  function automatic logic [1:0] err_weight(input logic [ERR_N-1:0] ev);
    return {1'b0, ev[0]} + {1'b0, ev[1]} + {1'b0, ev[2]};
  endfunction

endpackage

// File: rtl/rsfq_pulse_decoder_if.sv
// rsfq_pulse_decoder_if
//   Result bundle of the RSFQ pulse decoder.
//   master : driven by the decoder
//   slave  : read by the consumer (readout logic or bench)
//   Signals:
//     bit_o        decoded bit of the last closed period (held between strobes)
//     bit_valid_o  one-cycle strobe qualifying bit_o
//     err_*_o      sticky error flags (double / orphan / rate)
//     bit_count_o  saturating count of bit strobes
//     err_count_o  saturating count of error events
interface rsfq_pulse_decoder_if #(
  parameter int CNT_W = 16
);

  logic             bit_o;
  logic             bit_valid_o;
  logic             err_double_o;
  logic             err_orphan_o;
  logic             err_rate_o;
  logic [CNT_W-1:0] bit_count_o;
  logic [CNT_W-1:0] err_count_o;

  modport master (
    output bit_o,
    output bit_valid_o,
    output err_double_o,
    output err_orphan_o,
    output err_rate_o,
    output bit_count_o,
    output err_count_o
  );

  modport slave (
    input bit_o,
    input bit_valid_o,
    input err_double_o,
    input err_orphan_o,
    input err_rate_o,
    input bit_count_o,
    input err_count_o
  );

endinterface

// File: rtl/rsfq_edge_sync.sv
// rsfq_edge_sync
//   Synchronises one asynchronous toggle-encoded SFQ line into clk and turns
//   every level change into a one-cycle pulse.
//   Ports:
//     clk      sample clock
//     rst_n    asynchronous active-low reset (chain and history clear to 0)
//     line_i   asynchronous toggle-encoded pulse line
//     pulse_o  one-cycle strobe per edge of line_i, SYNC_STAGES+1 cycles
//              after the edge when consumed by a flop
module rsfq_edge_sync
  import rsfq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic pulse_o
);

  // Depths below the minimum are silently raised; one flop is not a synchroniser.
  localparam int STAGES = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], line_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // History resets to 0, so a line already high at reset release yields one pulse.
  assign pulse_o = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/rsfq_pulse_decoder.sv
// rsfq_pulse_decoder
//   Converts a toggle-encoded SFQ clock/data line pair into one clocked bit per
//   SFQ clock period and flags protocol/timing violations.
//
//   state | meaning
//   IDLE  | no acceptance window open; data pulses here are orphans
//   OPEN  | window running, win_cnt 0..WIN-1, hit/dbl accumulate data pulses
//
//   Ports:
//     clk, rst_n  sample clock, asynchronous active-low reset
//     en          decode enable; low forces IDLE and ignores pulses
//     clear_i     synchronous clear of counters and sticky flags
//     sfq_clk_i   toggle-encoded SFQ clock line (asynchronous)
//     sfq_q_i     toggle-encoded SFQ data line (asynchronous)
//     dec_if      result bundle (bit, strobe, sticky errors, counters)
module rsfq_pulse_decoder
  import rsfq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WIN         = 8,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clear_i,
  input  logic                        sfq_clk_i,
  input  logic                        sfq_q_i,
  rsfq_pulse_decoder_if.master        dec_if
);

  localparam int WIN_W = (WIN < 2) ? 1 : $clog2(WIN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);

  logic p_clk;
  logic p_q;

  rsfq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (sfq_clk_i),
    .pulse_o (p_clk)
  );

  rsfq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (sfq_q_i),
    .pulse_o (p_q)
  );

  state_e           state_q,      state_d;
  logic [WIN_W-1:0] win_cnt_q,    win_cnt_d;
  logic             hit_q,        hit_d;
  logic             dbl_q,        dbl_d;
  logic             bit_q,        bit_d;
  logic             bit_valid_q,  bit_valid_d;
  logic             err_double_q, err_double_d;
  logic             err_orphan_q, err_orphan_d;
  logic             err_rate_q,   err_rate_d;
  logic [CNT_W-1:0] bit_count_q,  bit_count_d;
  logic [CNT_W-1:0] err_count_q,  err_count_d;

  logic [ERR_N-1:0] err_ev;
  logic             hit_n;
  logic             dbl_n;
  logic             expire;
  logic [CNT_W:0]   bit_sum;
  logic [CNT_W:0]   err_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      win_cnt_q    <= '0;
      hit_q        <= 1'b0;
      dbl_q        <= 1'b0;
      bit_q        <= 1'b0;
      bit_valid_q  <= 1'b0;
      err_double_q <= 1'b0;
      err_orphan_q <= 1'b0;
      err_rate_q   <= 1'b0;
      bit_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      hit_q        <= hit_d;
      dbl_q        <= dbl_d;
      bit_q        <= bit_d;
      bit_valid_q  <= bit_valid_d;
      err_double_q <= err_double_d;
      err_orphan_q <= err_orphan_d;
      err_rate_q   <= err_rate_d;
      bit_count_q  <= bit_count_d;
      err_count_q  <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    hit_d       = hit_q;
    dbl_d       = dbl_q;
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    err_ev      = '0;
    hit_n       = hit_q;
    dbl_n       = dbl_q;
    expire      = (win_cnt_q == WIN_LAST);

    if (!en) begin
      // Disabled: drop any open window without a strobe.
      state_d   = IDLE;
      win_cnt_d = '0;
      hit_d     = 1'b0;
      dbl_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (p_clk) begin
            // A data pulse coincident with the opening clock belongs to the new window.
            state_d   = OPEN;
            win_cnt_d = '0;
            hit_d     = p_q;
            dbl_d     = 1'b0;
          end else if (p_q) begin
            err_ev[ERR_ORPHAN] = 1'b1;
          end
        end
        OPEN: begin
          // Data is folded in before the clock so a coincident pulse lands in the closing window.
          if (p_q) begin
            if (hit_q) begin
              dbl_n              = 1'b1;
              err_ev[ERR_DOUBLE] = 1'b1;
            end else begin
              hit_n = 1'b1;
            end
          end
          if (expire || p_clk) begin
            bit_valid_d = 1'b1;
            bit_d       = hit_n;
            if (p_clk) begin
              // Early clock closes and immediately reopens; only early arrival is a rate fault.
              err_ev[ERR_RATE] = !expire;
              state_d          = OPEN;
            end else begin
              state_d = IDLE;
            end
            win_cnt_d = '0;
            hit_d     = 1'b0;
            dbl_d     = 1'b0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            hit_d     = hit_n;
            dbl_d     = dbl_n;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    bit_sum = {1'b0, bit_count_q} + {{CNT_W{1'b0}}, bit_valid_d};
    err_sum = {1'b0, err_count_q} + {{(CNT_W-1){1'b0}}, err_weight(err_ev)};

    // Clear wins over any same-cycle event; counters stick at all-ones.
    if (clear_i) begin
      bit_count_d  = '0;
      err_count_d  = '0;
      err_double_d = 1'b0;
      err_orphan_d = 1'b0;
      err_rate_d   = 1'b0;
    end else begin
      bit_count_d  = bit_sum[CNT_W] ? {CNT_W{1'b1}} : bit_sum[CNT_W-1:0];
      err_count_d  = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
      err_double_d = err_double_q | err_ev[ERR_DOUBLE];
      err_orphan_d = err_orphan_q | err_ev[ERR_ORPHAN];
      err_rate_d   = err_rate_q   | err_ev[ERR_RATE];
    end
  end

  assign dec_if.bit_o        = bit_q;
  assign dec_if.bit_valid_o  = bit_valid_q;
  assign dec_if.err_double_o = err_double_q;
  assign dec_if.err_orphan_o = err_orphan_q;
  assign dec_if.err_rate_o   = err_rate_q;
  assign dec_if.bit_count_o  = bit_count_q;
  assign dec_if.err_count_o  = err_count_q;

endmodule

// File: tb/tb_rsfq_pulse_decoder.sv
// tb_rsfq_pulse_decoder
//   Directed scenarios followed by random toggles, all checked cycle by cycle
//   against an event-level reference model (window opened at an edge index,
//   closed by age or by the next clock pulse, data pulses counted per window).
module tb_rsfq_pulse_decoder;

  localparam int SYNC  = 2;
  localparam int WIN   = 8;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clear_i = 1'b0;
  logic sfq_clk_i = 1'b0;
  logic sfq_q_i = 1'b0;

  always #5 clk = ~clk;

  rsfq_pulse_decoder_if #(.CNT_W(CNT_W)) dec_if ();

  rsfq_pulse_decoder #(
    .SYNC_STAGES (SYNC),
    .WIN         (WIN),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clear_i   (clear_i),
    .sfq_clk_i (sfq_clk_i),
    .sfq_q_i   (sfq_q_i),
    .dec_if    (dec_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // reference model state
  bit hc [SYNC+2];
  bit hq [SYNC+2];
  bit m_open;
  int m_open_at;
  int m_hits;
  bit m_bit, m_valid, m_dbl, m_orph, m_rate;
  int m_bits, m_errs;

  // scenario bookkeeping
  int n_strobe;
  int first_strobe;
  int last_strobe;
  bit last_bit;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SYNC + 2; i++) begin
      hc[i] = 1'b0;
      hq[i] = 1'b0;
    end
    m_open = 0; m_open_at = 0; m_hits = 0;
    m_bit = 0; m_valid = 0; m_dbl = 0; m_orph = 0; m_rate = 0;
    m_bits = 0; m_errs = 0;
  endtask

  // One sample-clock edge: lc/lq are the line levels sampled at this edge.
  task automatic model_edge(input bit e, input bit clr, input bit lc, input bit lq);
    bit pc, pq, evd, evo, evr;
    int age;
    for (int i = SYNC + 1; i > 0; i--) begin
      hc[i] = hc[i-1];
      hq[i] = hq[i-1];
    end
    hc[0] = lc;
    hq[0] = lq;
    pc = hc[SYNC] ^ hc[SYNC+1];
    pq = hq[SYNC] ^ hq[SYNC+1];
    evd = 0; evo = 0; evr = 0;
    m_valid = 0;
    if (!e) begin
      m_open = 0;
    end else if (!m_open) begin
      if (pc) begin
        m_open = 1; m_open_at = cyc_n; m_hits = pq ? 1 : 0;
      end else if (pq) begin
        evo = 1;
      end
    end else begin
      age = cyc_n - m_open_at;
      if (pq) begin
        m_hits++;
        if (m_hits >= 2) evd = 1;
      end
      if (age >= WIN || pc) begin
        m_valid = 1;
        m_bit = (m_hits > 0);
        if (pc) begin
          if (age < WIN) evr = 1;
          m_open_at = cyc_n;
          m_hits = 0;
        end else begin
          m_open = 0;
        end
      end
    end
    if (m_valid) m_bits = sat(m_bits + 1);
    m_errs = sat(m_errs + int'(evd) + int'(evo) + int'(evr));
    m_dbl  = m_dbl | evd;
    m_orph = m_orph | evo;
    m_rate = m_rate | evr;
    if (clr) begin
      m_bits = 0; m_errs = 0; m_dbl = 0; m_orph = 0; m_rate = 0;
    end
  endtask

  task automatic compare_all(input string ph);
    check_eq({ph, "_bit"},    32'(dec_if.bit_o),        32'(m_bit));
    check_eq({ph, "_valid"},  32'(dec_if.bit_valid_o),  32'(m_valid));
    check_eq({ph, "_edbl"},   32'(dec_if.err_double_o), 32'(m_dbl));
    check_eq({ph, "_eorph"},  32'(dec_if.err_orphan_o), 32'(m_orph));
    check_eq({ph, "_erate"},  32'(dec_if.err_rate_o),   32'(m_rate));
    check_eq({ph, "_bitcnt"}, 32'(dec_if.bit_count_o),  32'(m_bits));
    check_eq({ph, "_errcnt"}, 32'(dec_if.err_count_o),  32'(m_errs));
  endtask

  task automatic cyc(input bit e, input bit clr, input bit tc, input bit tq);
    @(negedge clk);
    en = e;
    clear_i = clr;
    if (tc) sfq_clk_i = ~sfq_clk_i;
    if (tq) sfq_q_i = ~sfq_q_i;
    @(posedge clk);
    cyc_n++;
    model_edge(e, clr, sfq_clk_i, sfq_q_i);
    #1;
    compare_all("cyc");
    if (dec_if.bit_valid_o === 1'b1) begin
      n_strobe++;
      last_bit = dec_if.bit_o;
      last_strobe = cyc_n;
      if (first_strobe < 0) first_strobe = cyc_n;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sfq_clk_i = 1'b0;
    sfq_q_i = 1'b0;
    en = 1'b1;
    clear_i = 1'b0;
    #2;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_strobe = 0;
    first_strobe = -1;
    last_strobe = -1;
    last_bit = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1;
    model_reset();

    // S1: clock, data 5 cycles later -> one strobe of 1 after WIN cycles
    do_reset();
    idle(2);
    t0 = cyc_n + 1;
    cyc(1, 0, 1, 0);
    idle(4);
    cyc(1, 0, 0, 1);
    idle(15);
    check_eq("s1_strobes", 32'(n_strobe), 32'd1);
    check_eq("s1_latency", 32'(first_strobe - t0), 32'(SYNC + WIN));
    check_eq("s1_bit", 32'(last_bit), 32'd1);
    check_eq("s1_bitcnt", 32'(dec_if.bit_count_o), 32'd1);
    check_eq("s1_errcnt", 32'(dec_if.err_count_o), 32'd0);

    // S2: clock without data -> strobe of 0
    do_reset();
    cyc(1, 0, 1, 0);
    idle(15);
    check_eq("s2_strobes", 32'(n_strobe), 32'd1);
    check_eq("s2_bit", 32'(last_bit), 32'd0);
    check_eq("s2_bitcnt", 32'(dec_if.bit_count_o), 32'd1);

    // S3: two data pulses in one window
    do_reset();
    cyc(1, 0, 1, 0);
    idle(1);
    cyc(1, 0, 0, 1);
    idle(1);
    cyc(1, 0, 0, 1);
    idle(15);
    check_eq("s3_bit", 32'(last_bit), 32'd1);
    check_eq("s3_edbl", 32'(dec_if.err_double_o), 32'd1);
    check_eq("s3_errcnt", 32'(dec_if.err_count_o), 32'd1);

    // S4: orphan with en high, then with en low
    do_reset();
    cyc(1, 0, 0, 1);
    idle(8);
    check_eq("s4_eorph", 32'(dec_if.err_orphan_o), 32'd1);
    check_eq("s4_strobes", 32'(n_strobe), 32'd0);
    do_reset();
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    check_eq("s4_eorph_dis", 32'(dec_if.err_orphan_o), 32'd0);
    check_eq("s4_errcnt_dis", 32'(dec_if.err_count_o), 32'd0);

    // S5: clocks 3 cycles apart -> early close, rate error, second window normal
    do_reset();
    t0 = cyc_n + 1;
    cyc(1, 0, 1, 0);
    idle(2);
    t1 = cyc_n + 1;
    cyc(1, 0, 1, 0);
    idle(15);
    check_eq("s5_strobes", 32'(n_strobe), 32'd2);
    check_eq("s5_first_lat", 32'(first_strobe - t0), 32'(SYNC + 3));
    check_eq("s5_second_lat", 32'(last_strobe - t1), 32'(SYNC + WIN));
    check_eq("s5_erate", 32'(dec_if.err_rate_o), 32'd1);
    check_eq("s5_bitcnt", 32'(dec_if.bit_count_o), 32'd2);

    // S6: reset mid-window abandons it
    do_reset();
    cyc(1, 0, 1, 0);
    idle(4);
    do_reset();
    idle(15);
    check_eq("s6_strobes", 32'(n_strobe), 32'd0);
    check_eq("s6_bitcnt", 32'(dec_if.bit_count_o), 32'd0);

    // S7: clear in the same cycle as an orphan
    do_reset();
    cyc(1, 0, 0, 1);
    idle(SYNC - 1);
    cyc(1, 1, 0, 0);
    idle(3);
    check_eq("s7_eorph", 32'(dec_if.err_orphan_o), 32'd0);
    check_eq("s7_errcnt", 32'(dec_if.err_count_o), 32'd0);

    // S8: error counter saturates
    do_reset();
    for (int i = 0; i < MAXC + 5; i++) begin
      cyc(1, 0, 0, 1);
      idle(1);
    end
    idle(4);
    check_eq("s8_errsat", 32'(dec_if.err_count_o), 32'(MAXC));

    // Random phase
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc(($urandom_range(0, 15) != 0),
          ($urandom_range(0, 63) == 0),
          ($urandom_range(0, 6) == 0),
          ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
